// File: rtl/seri_mul_arb.sv
// seri_mul_arb: round-robin arbiter that shares one 8x8 serial multiplier
// (seri_mul) among NREQ requesters. One request is granted at a time. The
// multiplier is launched with a single-cycle en_mul pulse, and the 16-bit
// product is returned to the winner. A watchdog ends an operation that never
// reports op_done and returns an error response instead.
module seri_mul_arb #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   req_a,
   input  logic [8*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]     ack,
   output logic [NREQ-1:0]     rsp_vld,
   output logic [15:0]         rsp_product,
   output logic                rsp_err,
   output logic                busy,
   output logic [7:0]          mul_a,
   output logic [7:0]          mul_b,
   output logic                en_mul,
   input  logic [15:0]         product,
   input  logic                op_done
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2
   } state_t;

   state_t            state_reg;
   logic [IDX_W-1:0]  ptr_reg;
   logic [IDX_W-1:0]  win_id_reg;
   logic [WD_W-1:0]   wd_reg;
   logic [NREQ-1:0]   ack_reg;
   logic [NREQ-1:0]   rsp_vld_reg;
   logic [15:0]       rsp_product_reg;
   logic              rsp_err_reg;
   logic [7:0]        mul_a_reg;
   logic [7:0]        mul_b_reg;
   logic              en_mul_reg;

   // Per-requester operand views and one-hot decodes of the chosen index
   logic [7:0]        op_a [NREQ];
   logic [7:0]        op_b [NREQ];
   logic [NREQ-1:0]   win_onehot;
   logic [NREQ-1:0]   rsp_onehot;

   // Arbitration result for the current cycle
   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  ptr_next;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign op_a[gi]       = req_a[8*gi +: 8];
         assign op_b[gi]       = req_b[8*gi +: 8];
         assign win_onehot[gi] = (win_idx == IDX_W'(gi));
         assign rsp_onehot[gi] = (win_id_reg == IDX_W'(gi));
      end
   endgenerate

   // Round-robin scan: walk offsets from the highest down so the request
   // closest to ptr (smallest offset, wrapping) is the one left standing
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_reg) + k) % NREQ;
         if (req[IDX_W'(idx)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(idx);
         end
      end
      ptr_next = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
   end

   // Sequencer: grant in IDLE, pulse en_mul/ack in LAUNCH, wait for op_done
   // or the watchdog in BUSY; ack, en_mul, rsp_vld and rsp_err are one-cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg       <= IDLE;
         ptr_reg         <= '0;
         win_id_reg      <= '0;
         wd_reg          <= '0;
         ack_reg         <= '0;
         rsp_vld_reg     <= '0;
         rsp_product_reg <= '0;
         rsp_err_reg     <= 1'b0;
         mul_a_reg       <= '0;
         mul_b_reg       <= '0;
         en_mul_reg      <= 1'b0;
      end else begin
         ack_reg     <= '0;
         en_mul_reg  <= 1'b0;
         rsp_vld_reg <= '0;
         rsp_err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // op_done is deliberately not looked at here: a stray
               // completion with nothing outstanding produces no response
               if (win_found) begin
                  mul_a_reg  <= op_a[win_idx];
                  mul_b_reg  <= op_b[win_idx];
                  ack_reg    <= win_onehot;
                  en_mul_reg <= 1'b1;
                  win_id_reg <= win_idx;
                  ptr_reg    <= ptr_next;
                  state_reg  <= LAUNCH;
               end
            end
            LAUNCH: begin
               // The multiplier sees en_mul during this cycle; any op_done
               // now cannot belong to the new operation
               wd_reg    <= '0;
               state_reg <= BUSY;
            end
            BUSY: begin
               if (op_done) begin
                  // A completion on the watchdog's last edge still counts
                  rsp_product_reg <= product;
                  rsp_vld_reg     <= rsp_onehot;
                  state_reg       <= IDLE;
               end else if (wd_reg == WD_LAST) begin
                  rsp_product_reg <= '0;
                  rsp_vld_reg     <= rsp_onehot;
                  rsp_err_reg     <= 1'b1;
                  state_reg       <= IDLE;
               end else begin
                  wd_reg <= wd_reg + WD_W'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign ack         = ack_reg;
   assign rsp_vld     = rsp_vld_reg;
   assign rsp_product = rsp_product_reg;
   assign rsp_err     = rsp_err_reg;
   assign mul_a       = mul_a_reg;
   assign mul_b       = mul_b_reg;
   assign en_mul      = en_mul_reg;
   assign busy        = (state_reg != IDLE);

endmodule
